// File: rtl/reduce_pipe.sv
// reduce_pipe: pipelined bit-reduction unit with packet accumulation.
//
// Reduces a WIDTH-bit word with a selectable operator (OR, AND, XOR, NOR)
// through a two-input tree. A register stage follows every LEVELS_PER_STAGE
// levels. Beat results are folded into an accumulator across a multi-beat
// packet, and one result per packet is returned over a valid/ready handshake.
//
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous, active-high reset
//   in_valid   : input beat present
//   in_ready   : beat accepted this cycle when in_valid is also high
//   in_data    : word to reduce
//   in_op      : 00 OR, 01 AND, 10 XOR, 11 NOR (captured on a packet's first beat)
//   in_last    : final beat of the packet
//   out_valid  : packet result available
//   out_ready  : consumer takes the result
//   out_bit    : reduced result over all beats of the packet
//   out_count  : beats in the packet, saturating at all-ones
module reduce_pipe #(
  parameter int WIDTH            = 16,
  parameter int LEVELS_PER_STAGE = 2,
  parameter int CNT_W            = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic [CNT_W-1:0] out_count
);

  localparam int LOG2W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_t;

  // NOR reduces with OR; the inversion is applied once at the output.
  function automatic logic combine(input logic a, input logic b, input op_t op);
    case (op)
      OP_AND:  return a & b;
      OP_XOR:  return a ^ b;
      default: return a | b;
    endcase
  endfunction

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Packet-start tracking and operator capture at the input.
  logic first;
  op_t  op_hold;
  op_t  head_op;

  assign head_op = first ? op_t'(in_op) : op_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first   <= 1'b1;
      op_hold <= OP_OR;
    end else if (in_valid && en) begin
      first <= in_last;
      if (first) begin
        op_hold <= op_t'(in_op);
      end
    end
  end

  // One generate iteration per tree level, each sized to exactly the bits it
  // produces. A level either registers its result (stage boundary or final
  // level) or passes it straight through to the next level.
  for (genvar l = 1; l <= LOG2W; l++) begin : g_lvl
    localparam int unsigned OW      = WIDTH >> l;
    localparam bit          REG_OUT = ((l % LEVELS_PER_STAGE) == 0) || (l == LOG2W);

    logic [2*OW-1:0] src;
    op_t             src_op;
    logic            src_valid;
    logic            src_last;
    logic            src_first;
    logic [OW-1:0]   red;

    logic [OW-1:0]   q;
    op_t             q_op;
    logic            q_valid;
    logic            q_last;
    logic            q_first;

    if (l == 1) begin : g_from_in
      assign src       = in_data;
      assign src_op    = head_op;
      assign src_valid = in_valid;
      assign src_last  = in_last;
      assign src_first = first;
    end else begin : g_from_prev
      assign src       = g_lvl[l-1].q;
      assign src_op    = g_lvl[l-1].q_op;
      assign src_valid = g_lvl[l-1].q_valid;
      assign src_last  = g_lvl[l-1].q_last;
      assign src_first = g_lvl[l-1].q_first;
    end

    always_comb begin
      red = '0;
      for (int unsigned i = 0; i < OW; i++) begin
        red[i] = combine(src[2*i], src[2*i+1], src_op);
      end
    end

    if (REG_OUT) begin : g_reg
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          q       <= '0;
          q_op    <= OP_OR;
          q_valid <= 1'b0;
          q_last  <= 1'b0;
          q_first <= 1'b0;
        end else if (en) begin
          q       <= red;
          q_op    <= src_op;
          q_valid <= src_valid;
          q_last  <= src_last;
          q_first <= src_first;
        end
      end
    end else begin : g_comb
      assign q       = red;
      assign q_op    = src_op;
      assign q_valid = src_valid;
      assign q_last  = src_last;
      assign q_first = src_first;
    end
  end

  // Accumulator and output register.
  logic             beat;
  op_t              tail_op;
  logic             tail_valid;
  logic             tail_last;
  logic             tail_first;
  logic             acc;
  logic [CNT_W-1:0] cnt;
  logic             acc_next;
  logic [CNT_W-1:0] cnt_next;

  assign beat       = g_lvl[LOG2W].q[0];
  assign tail_op    = g_lvl[LOG2W].q_op;
  assign tail_valid = g_lvl[LOG2W].q_valid;
  assign tail_last  = g_lvl[LOG2W].q_last;
  assign tail_first = g_lvl[LOG2W].q_first;

  always_comb begin
    acc_next = beat;
    cnt_next = CNT_W'(1);
    if (!tail_first) begin
      acc_next = combine(acc, beat, tail_op);
      cnt_next = (cnt == '1) ? cnt : cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_count <= '0;
    end else if (en) begin
      out_valid <= 1'b0;
      if (tail_valid) begin
        acc <= acc_next;
        cnt <= cnt_next;
        if (tail_last) begin
          out_valid <= 1'b1;
          out_bit   <= (tail_op == OP_NOR) ? ~acc_next : acc_next;
          out_count <= cnt_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_reduce_pipe.sv
module tb_reduce_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Default configuration: WIDTH=16, LEVELS_PER_STAGE=2, CNT_W=8
  logic        in_valid, in_ready, in_last, out_valid, out_ready, out_bit;
  logic [15:0] in_data;
  logic [1:0]  in_op;
  logic [7:0]  out_count;

  // WIDTH=64, LEVELS_PER_STAGE=1, CNT_W=2
  logic        a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_bit;
  logic [63:0] a_in_data;
  logic [1:0]  a_in_op;
  logic [1:0]  a_out_count;

  // WIDTH=2, LEVELS_PER_STAGE=6, CNT_W=8
  logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_bit;
  logic [1:0]  b_in_data;
  logic [1:0]  b_in_op;
  logic [7:0]  b_out_count;

  int checks   = 0;
  int failures = 0;

  reduce_pipe #(.WIDTH(16), .LEVELS_PER_STAGE(2), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_op(in_op), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bit(out_bit), .out_count(out_count)
  );

  reduce_pipe #(.WIDTH(64), .LEVELS_PER_STAGE(1), .CNT_W(2)) dut_a (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_op(a_in_op), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_bit(a_out_bit), .out_count(a_out_count)
  );

  reduce_pipe #(.WIDTH(2), .LEVELS_PER_STAGE(6), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_op(b_in_op), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_bit(b_out_bit), .out_count(b_out_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat for one cycle on the default unit (out_ready held high).
  task automatic drive(input logic [15:0] d, input logic [1:0] op, input logic last);
    in_valid = 1'b1; in_data = d; in_op = op; in_last = last;
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Edges from acceptance of the last beat until out_valid, bounded.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_bit !== 1'b0) begin failures++; $display("FAIL reset_out_bit got=%0b exp=0", out_bit); end
    checks++; if (out_count !== 8'd0) begin failures++; $display("FAIL reset_out_count got=%0d exp=0", out_count); end
    checks++; if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin failures++; $display("FAIL reset_aux_valid got=%0b%0b exp=00", a_out_valid, b_out_valid); end
    reset = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_single_or();
    int lat;
    drive(16'h0000, 2'b00, 1'b1);
    wait_out(lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL or0_latency got=%0d exp=3", lat); end
    checks++; if (out_bit !== 1'b0) begin failures++; $display("FAIL or0_bit got=%0b exp=0", out_bit); end
    checks++; if (out_count !== 8'd1) begin failures++; $display("FAIL or0_count got=%0d exp=1", out_count); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL or0_consumed got=%0b exp=0", out_valid); end
    drive(16'h0100, 2'b00, 1'b1);
    wait_out(lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL or1_latency got=%0d exp=3", lat); end
    checks++; if (out_bit !== 1'b1) begin failures++; $display("FAIL or1_bit got=%0b exp=1", out_bit); end
    checks++; if (out_count !== 8'd1) begin failures++; $display("FAIL or1_count got=%0d exp=1", out_count); end
  endtask

  task automatic test_op_capture();
    int lat;
    // AND captured on beat 1; OR on later beats is ignored (OR would give 1).
    drive(16'hFFFF, 2'b01, 1'b0);
    drive(16'hFFFF, 2'b00, 1'b0);
    drive(16'hFFFE, 2'b00, 1'b1);
    wait_out(lat);
    checks++; if (out_bit !== 1'b0) begin failures++; $display("FAIL and3_bit got=%0b exp=0", out_bit); end
    checks++; if (out_count !== 8'd3) begin failures++; $display("FAIL and3_count got=%0d exp=3", out_count); end
    // OR captured on beat 1; AND on later beats is ignored (AND would give 0).
    drive(16'h0000, 2'b00, 1'b0);
    drive(16'h0000, 2'b01, 1'b0);
    drive(16'h0001, 2'b01, 1'b1);
    wait_out(lat);
    checks++; if (out_bit !== 1'b1) begin failures++; $display("FAIL or3_bit got=%0b exp=1", out_bit); end
    checks++; if (out_count !== 8'd3) begin failures++; $display("FAIL or3_count got=%0d exp=3", out_count); end
  endtask

  task automatic test_xor_nor();
    int lat;
    // XOR parity with idle cycles between beats: three ones -> 1
    drive(16'h0001, 2'b10, 1'b0);
    step();
    step();
    drive(16'h0003, 2'b10, 1'b1);
    wait_out(lat);
    checks++; if (out_bit !== 1'b1) begin failures++; $display("FAIL xor_bit got=%0b exp=1", out_bit); end
    checks++; if (out_count !== 8'd2) begin failures++; $display("FAIL xor_count got=%0d exp=2", out_count); end
    drive(16'h0000, 2'b11, 1'b0);
    drive(16'h0000, 2'b11, 1'b1);
    wait_out(lat);
    checks++; if (out_bit !== 1'b1) begin failures++; $display("FAIL nor_bit got=%0b exp=1", out_bit); end
    checks++; if (out_count !== 8'd2) begin failures++; $display("FAIL nor_count got=%0d exp=2", out_count); end
    drive(16'h0010, 2'b11, 1'b1);
    wait_out(lat);
    checks++; if (out_bit !== 1'b0) begin failures++; $display("FAIL nor1_bit got=%0b exp=0", out_bit); end
    checks++; if (out_count !== 8'd1) begin failures++; $display("FAIL nor1_count got=%0d exp=1", out_count); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] bd [4] = '{16'h0001, 16'h7FFF, 16'h0101, 16'h0000};
    logic [1:0]  bo [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic        be [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i < 4) begin
        in_valid = 1'b1; in_data = bd[i]; in_op = bo[i]; in_last = 1'b1;
      end else begin
        in_valid = 1'b0; in_last = 1'b0;
      end
      step();
      if (i >= 2 && i < 6) begin
        checks++;
        if (out_valid !== 1'b1 || out_bit !== be[i-2] || out_count !== 8'd1) begin
          failures++;
          $display("FAIL b2b_result%0d got=v%0b/b%0b/c%0d exp=v1/b%0b/c1", i-2, out_valid, out_bit, out_count, be[i-2]);
        end
      end
      if (i == 6) begin
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0b exp=0", out_valid); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] pd [4] = '{16'h0001, 16'h0000, 16'h0007, 16'hFFFE};
    logic [1:0]  po [4] = '{2'b00, 2'b00, 2'b10, 2'b01};
    logic        pe [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic        got [4];
    int          k = 0;
    int          nres = 0;
    logic        acc;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (cyc == 20) begin
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_low got=%0b exp=0", in_ready); end
        checks++; if (k !== 3) begin failures++; $display("FAIL bp_accepted got=%0d exp=3", k); end
        checks++; if (out_valid !== 1'b1 || out_bit !== pe[0]) begin failures++; $display("FAIL bp_hold got=v%0b/b%0b exp=v1/b%0b", out_valid, out_bit, pe[0]); end
        out_ready = 1'b1;
      end
      if (k < 4) begin
        in_valid = 1'b1; in_data = pd[k]; in_op = po[k]; in_last = 1'b1;
      end else begin
        in_valid = 1'b0; in_last = 1'b0;
      end
      if (out_valid && out_ready && nres < 4) begin
        got[nres] = out_bit;
        nres++;
      end
      acc = in_valid && in_ready;
      step();
      if (acc) k++;
      if (nres == 4 && k == 4) break;
    end
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (nres !== 4) begin failures++; $display("FAIL bp_result_count got=%0d exp=4", nres); end
    for (int i = 0; i < 4; i++) begin
      if (i < nres) begin
        checks++; if (got[i] !== pe[i]) begin failures++; $display("FAIL bp_order%0d got=%0b exp=%0b", i, got[i], pe[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    out_ready = 1'b1;
    drive(16'h0100, 2'b00, 1'b1);
    drive(16'h8000, 2'b00, 1'b0);
    drive(16'h8000, 2'b00, 1'b0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rmid_pre_valid got=%0b exp=1", out_valid); end
    #1 reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_bit !== 1'b0 || out_count !== 8'd0) begin
      failures++; $display("FAIL rmid_async got=v%0b/b%0b/c%0d exp=v0/b0/c0", out_valid, out_bit, out_count);
    end
    #1 reset = 1'b0;
    step();
    drive(16'h0000, 2'b00, 1'b1);
    wait_out(lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL rmid_latency got=%0d exp=3", lat); end
    checks++; if (out_bit !== 1'b0) begin failures++; $display("FAIL rmid_bit got=%0b exp=0", out_bit); end
    checks++; if (out_count !== 8'd1) begin failures++; $display("FAIL rmid_count got=%0d exp=1", out_count); end
  endtask

  task automatic test_params();
    int lat;
    // WIDTH=64, LEVELS_PER_STAGE=1: six register stages plus output
    a_in_valid = 1'b1; a_in_data = 64'h8000_0000_0000_0000; a_in_op = 2'b00; a_in_last = 1'b1;
    step();
    a_in_valid = 1'b0; a_in_last = 1'b0;
    lat = 1;
    while (!a_out_valid && lat < 30) begin step(); lat++; end
    checks++; if (lat !== 7) begin failures++; $display("FAIL w64_latency got=%0d exp=7", lat); end
    checks++; if (a_out_bit !== 1'b1 || a_out_count !== 2'd1) begin failures++; $display("FAIL w64_result got=b%0b/c%0d exp=b1/c1", a_out_bit, a_out_count); end
    // CNT_W=2: five beats saturate at 3
    for (int i = 0; i < 5; i++) begin
      a_in_valid = 1'b1; a_in_data = 64'hFFFF_FFFF_FFFF_FFFF; a_in_op = 2'b01; a_in_last = (i == 4);
      step();
    end
    a_in_valid = 1'b0; a_in_last = 1'b0;
    lat = 1;
    while (!a_out_valid && lat < 30) begin step(); lat++; end
    checks++; if (a_out_count !== 2'd3) begin failures++; $display("FAIL cnt_sat got=%0d exp=3", a_out_count); end
    checks++; if (a_out_bit !== 1'b1) begin failures++; $display("FAIL cnt_sat_bit got=%0b exp=1", a_out_bit); end
    // WIDTH=2, LEVELS_PER_STAGE=6: single stage plus output
    b_in_valid = 1'b1; b_in_data = 2'b10; b_in_op = 2'b10; b_in_last = 1'b1;
    step();
    b_in_valid = 1'b0; b_in_last = 1'b0;
    lat = 1;
    while (!b_out_valid && lat < 30) begin step(); lat++; end
    checks++; if (lat !== 2) begin failures++; $display("FAIL w2_latency got=%0d exp=2", lat); end
    checks++; if (b_out_bit !== 1'b1) begin failures++; $display("FAIL w2_xor got=%0b exp=1", b_out_bit); end
    b_in_valid = 1'b1; b_in_data = 2'b10; b_in_op = 2'b01; b_in_last = 1'b1;
    step();
    b_in_valid = 1'b0; b_in_last = 1'b0;
    lat = 1;
    while (!b_out_valid && lat < 30) begin step(); lat++; end
    checks++; if (b_out_valid !== 1'b1 || b_out_bit !== 1'b0) begin failures++; $display("FAIL w2_and got=v%0b/b%0b exp=v1/b0", b_out_valid, b_out_bit); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0; in_data = '0; in_op = '0; in_last = 1'b0; out_ready = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_in_op = '0; a_in_last = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_op = '0; b_in_last = 1'b0; b_out_ready = 1'b1;

    test_reset();
    test_single_or();
    test_op_capture();
    test_xor_nor();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_params();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reduce_pipe.md
# reduce_pipe

Parametrised, pipelined bit-reduction unit and the successor to the fixed 16-input OR tree. It reduces a WIDTH-bit word with a selectable operator (OR, AND, XOR, NOR) through a registered tree. It also accumulates the result across a multi-beat packet and returns one result per packet over a valid/ready handshake. It sits between ALU-side status generation and any consumer that needs zero, all-ones or parity flags over wide or multi-word data.

## Interface

Parameters:

- WIDTH, 16: input word width. Power of two, 2..64.
- LEVELS_PER_STAGE, 2: two-input tree levels between pipeline registers, 1..6.
- CNT_W, 8: width of the beat counter.
- Derived: STAGES = ceil(log2(WIDTH) / LEVELS_PER_STAGE), minimum 1.

Ports:

- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: input beat present.
- in_ready, output, 1: unit accepts a beat this cycle.
- in_data, input, WIDTH: word to reduce.
- in_op, input, 2: operator. 00 OR, 01 AND, 10 XOR, 11 NOR. Sampled on the first beat of a packet only.
- in_last, input, 1: beat is the final beat of its packet.
- out_valid, output, 1: packet result available.
- out_ready, input, 1: consumer takes the result.
- out_bit, output, 1: reduced result over all beats of the packet.
- out_count, output, CNT_W: number of beats in the packet, saturating at 2^CNT_W-1.

## Operation

- Beat accepted when in_valid && in_ready.
- Global advance enable: en = !out_valid || out_ready.
- in_ready = en. The whole pipeline stalls as one unit; nothing inside it is lost or duplicated.
- Tree reduction:
  - Each level combines adjacent pairs with the base operator: OR for OR and NOR, AND for AND, XOR for XOR.
  - Every LEVELS_PER_STAGE levels are followed by a register stage.
  - Each stage carries valid, op, last and a first flag alongside the data.
- Packet state:
  - A first flag is held internally and set after reset and after any accepted in_last beat.
  - On a beat with first = 1, in_op is captured. It travels with all subsequent beats of the same packet.
  - in_op on later beats is ignored.
- Accumulator (final stage):
  - On a first beat: acc = beat_result, cnt = 1.
  - On other beats: acc = acc op_base beat_result, cnt = cnt + 1. cnt saturates at all-ones.
  - On a last beat: out_valid is set, with out_bit = acc (inverted for NOR) and out_count = cnt.
  - Non-last beats never raise out_valid.
- Single-beat packet: first and last on the same beat. The result equals a plain reduction of that word.
- Output holds stable while out_valid && !out_ready.
- out_valid clears on out_ready unless a new last beat completes in the same cycle.

## Timing

- Latency from acceptance of a last beat to out_valid is STAGES+1 cycles when there is no backpressure. With WIDTH=16 and LEVELS_PER_STAGE=2 this is 3 cycles.
- Throughput is one beat per cycle while out_ready is held high.
- Simultaneous events:
  - Result consumed and a new result arriving in the same cycle: out_valid stays 1 and out_bit/out_count update to the new packet.
  - in_last with first = 1: a one-beat packet; the counter resets to 1, not 2.
- Reset values, applied asynchronously:
  - out_valid 0, out_bit 0, out_count 0.
  - All stage valids 0, acc 0, cnt 0, first 1.
  - in_ready 1 from the first clock after reset release.
- Reset mid-packet: partial accumulation is discarded. The next accepted beat starts a new packet.
- in_valid low between beats of a packet is legal. The accumulator holds its state across the gaps.

## Test plan

- Single beat, OR: in_data=16'h0000, op=00, last=1 -> out_bit=0, out_count=1 three cycles later. Repeat with 16'h0100 -> out_bit=1.
- Three-beat AND packet, words FFFF, FFFF, FFFE, op=01 on beat 1 only -> out_bit=0, out_count=3. Changing op to 00 on beats 2–3 has no effect.
- XOR parity over beats 0x0001, 0x0003 (three ones in total) -> out_bit=1. NOR over 0x0000, 0x0000 -> out_bit=1, out_count=2.
- Backpressure: out_ready=0 while four single-beat packets are offered.
  - in_ready falls once out_valid is set and the pipeline is full.
  - Release out_ready -> all four results appear in order with none lost.
- Reset asserted mid-packet, after 2 beats of OR 0x8000 -> outputs go to 0 immediately. A following single-beat packet 0x0000 yields out_bit=0, out_count=1.
- Parameter sweep:
  - WIDTH=64, LEVELS_PER_STAGE=1 -> latency 7.
  - WIDTH=2, LEVELS_PER_STAGE=6 -> latency 2.
  - CNT_W=2 with a 5-beat packet -> out_count=3.
